// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - issue controller: decodes RISC-V ALU/branch/mem ops, drives an external ALU, returns result
module alu_issue_ctrl #(
    parameter int         XLEN       = 32,
    parameter logic [6:0] SUB_FUNCT7 = 7'b0100000
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            In_Valid,
    output logic            In_Ready,
    input  logic [31:0]     Instr,
    input  logic [XLEN-1:0] Rs1_Data,
    input  logic [XLEN-1:0] Rs2_Data,
    output logic [XLEN-1:0] Alu_A,
    output logic [XLEN-1:0] Alu_B,
    output logic [3:0]      Alu_Sel,
    input  logic [XLEN-1:0] Alu_Out,
    input  logic            Alu_Carry,
    input  logic            Alu_Zero,
    input  logic            Alu_Overflow,
    output logic            Res_Valid,
    input  logic            Res_Ready,
    output logic [XLEN-1:0] Result,
    output logic            Branch_Taken,
    output logic [2:0]      Flags,
    output logic            Illegal
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    // Branch kind records which ALU answer means "taken".
    typedef enum logic [1:0] {BR_NONE, BR_ONE, BR_ZERO} br_t;

    localparam logic [3:0] SEL_AND = 4'b0000;
    localparam logic [3:0] SEL_OR  = 4'b0001;
    localparam logic [3:0] SEL_ADD = 4'b0010;
    localparam logic [3:0] SEL_SUB = 4'b0110;
    localparam logic [3:0] SEL_SLT = 4'b0111;
    localparam logic [3:0] SEL_EQ  = 4'b1111;

    state_t state, state_next;
    br_t    br_kind, dec_br;

    logic [6:0]      opcode, funct7;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm_i, imm_s, dec_b;
    logic [3:0]      dec_sel;
    logic            dec_ill;
    logic            unused_rs1_field;

    assign opcode = Instr[6:0];
    assign funct3 = Instr[14:12];
    assign funct7 = Instr[31:25];
    assign imm_i  = {{(XLEN-12){Instr[31]}}, Instr[31:20]};
    assign imm_s  = {{(XLEN-12){Instr[31]}}, Instr[31:25], Instr[11:7]};
    assign unused_rs1_field = ^Instr[19:15];

    always_comb begin
        dec_ill = 1'b1;
        dec_sel = SEL_AND;
        dec_b   = Rs2_Data;
        dec_br  = BR_NONE;
        case (opcode)
            7'b0110011: begin
                if (funct7 == 7'b0000000) begin
                    dec_ill = 1'b0;
                    case (funct3)
                        3'b000:  dec_sel = SEL_ADD;
                        3'b111:  dec_sel = SEL_AND;
                        3'b110:  dec_sel = SEL_OR;
                        3'b010:  dec_sel = SEL_SLT;
                        default: dec_ill = 1'b1;
                    endcase
                end else if (funct7 == SUB_FUNCT7 && funct3 == 3'b000) begin
                    dec_ill = 1'b0;
                    dec_sel = SEL_SUB;
                end
            end
            7'b0010011: begin
                dec_b   = imm_i;
                dec_ill = 1'b0;
                case (funct3)
                    3'b000:  dec_sel = SEL_ADD;
                    3'b010:  dec_sel = SEL_SLT;
                    3'b110:  dec_sel = SEL_OR;
                    3'b111:  dec_sel = SEL_AND;
                    default: dec_ill = 1'b1;
                endcase
            end
            7'b0000011: begin
                dec_b   = imm_i;
                dec_sel = SEL_ADD;
                dec_ill = 1'b0;
            end
            7'b0100011: begin
                dec_b   = imm_s;
                dec_sel = SEL_ADD;
                dec_ill = 1'b0;
            end
            7'b1100011: begin
                dec_ill = 1'b0;
                case (funct3)
                    3'b000: begin dec_sel = SEL_EQ;  dec_br = BR_ONE;  end
                    3'b001: begin dec_sel = SEL_EQ;  dec_br = BR_ZERO; end
                    3'b100: begin dec_sel = SEL_SLT; dec_br = BR_ONE;  end
                    3'b101: begin dec_sel = SEL_SLT; dec_br = BR_ZERO; end
                    default: dec_ill = 1'b1;
                endcase
            end
            default: dec_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (In_Valid) state_next = dec_ill ? RESP : EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (Res_Ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign In_Ready  = (state == IDLE);
    assign Res_Valid = (state == RESP);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            br_kind      <= BR_NONE;
            Alu_A        <= '0;
            Alu_B        <= '0;
            Alu_Sel      <= SEL_AND;
            Result       <= '0;
            Flags        <= '0;
            Branch_Taken <= 1'b0;
            Illegal      <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && In_Valid) begin
                if (dec_ill) begin
                    // Operand registers deliberately keep the last legal request.
                    Illegal      <= 1'b1;
                    Result       <= '0;
                    Flags        <= '0;
                    Branch_Taken <= 1'b0;
                end else begin
                    Alu_A   <= Rs1_Data;
                    Alu_B   <= dec_b;
                    Alu_Sel <= dec_sel;
                    br_kind <= dec_br;
                end
            end else if (state == EXEC) begin
                Result       <= Alu_Out;
                Flags        <= {Alu_Carry, Alu_Overflow, Alu_Zero};
                Illegal      <= 1'b0;
                Branch_Taken <= (br_kind == BR_ONE  && Alu_Out == {{(XLEN-1){1'b0}}, 1'b1}) ||
                                (br_kind == BR_ZERO && Alu_Out == '0);
            end
        end
    end

endmodule
